multi_packet_input_buffer: RTL and testbench

Per-virtual-channel input buffer for the router input port that, unlike the single-packet buffer, queues up to MAX_PACKETS complete or partial packets back-to-back in one VC. It stores flits, keeps a queue of next-hop ports (one per buffered packet), and runs the IDLE/VA/SA pipeline FSM on the packet at the head. It returns one credit per flit read instead of on/off backpressure. One instance sits per VC inside the input port, feeding the VC and switch allocators.

---
 rtl/noc_params.sv | 36 +++
 rtl/multi_packet_input_buffer_sync_fifo.sv | 56 +++++
 rtl/multi_packet_input_buffer.sv | 166 ++++++++++++++++
 tb/tb_multi_packet_input_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// Shared NoC types: flit labels, port identifiers and flit formats.
// flit_novc_t is the flit as it arrives on the input link; flit_t carries the
// downstream virtual-channel id added on the way out of the buffer.
package noc_params;

    localparam int unsigned VC_NUM    = 4;
    localparam int unsigned VC_SIZE   = $clog2(VC_NUM);
    localparam int unsigned DATA_SIZE = 16;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [DATA_SIZE-1:0] data;
    } flit_novc_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [VC_SIZE-1:0]   vc_id;
        logic [DATA_SIZE-1:0] data;
    } flit_t;

endpackage

// File: rtl/multi_packet_input_buffer_sync_fifo.sv
// Generic synchronous FIFO with asynchronous active-high reset.
// Depth need not be a power of two; pointers wrap explicitly at DEPTH-1.
// Ports: clk, rst, push_i/wdata_i (write), pop_i (read), rdata_o (front entry,
// combinational), full_o, empty_o, count_o (entries stored).
// The caller must not push when full or pop when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push_i && !pop_i)      count_q <= count_q + 1'b1;
            else if (pop_i && !push_i) count_q <= count_q - 1'b1;
        end
    end

    // Storage array needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/multi_packet_input_buffer.sv
// Per-VC router input buffer holding up to MAX_PACKETS packets back-to-back.
// Flits go into one FIFO, each accepted head's route into a second FIFO; the
// IDLE/VA/SA FSM serves the packet at the head and returns one credit per pop.
// Ports: data_i/write_i/out_port_i (link write), read_i (switch grant),
// vc_valid_i/vc_new_i (VC grant); data_o (front flit), is_full_o, is_empty_o,
// occupancy_o, credit_o, out_port_o, vc_request_o, switch_request_o,
// vc_allocatable_o, downstream_vc_o, error_o.
module multi_packet_input_buffer
    import noc_params::*;
#(
    parameter int unsigned BUFFER_SIZE = 8,
    parameter int unsigned MAX_PACKETS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  flit_novc_t                       data_i,
    input  logic                             write_i,
    input  port_t                            out_port_i,
    input  logic                             read_i,
    input  logic                             vc_valid_i,
    input  logic [VC_SIZE-1:0]               vc_new_i,
    output flit_t                            data_o,
    output logic                             is_full_o,
    output logic                             is_empty_o,
    output logic [$clog2(BUFFER_SIZE+1)-1:0] occupancy_o,
    output logic                             credit_o,
    output port_t                            out_port_o,
    output logic                             vc_request_o,
    output logic                             switch_request_o,
    output logic                             vc_allocatable_o,
    output logic [VC_SIZE-1:0]               downstream_vc_o,
    output logic                             error_o
);

    localparam int unsigned FlitW = $bits(flit_novc_t);
    localparam int unsigned PortW = $bits(port_t);

    typedef enum logic [1:0] {StIdle = 2'd0, StVa = 2'd1, StSa = 2'd2} state_t;

    state_t             state_q;
    logic               in_pkt_q;
    logic [VC_SIZE-1:0] downstream_vc_q;
    logic               credit_q, vc_alloc_q, error_q;

    logic [FlitW-1:0] flit_rdata;
    logic [PortW-1:0] rq_rdata;
    logic             flit_full, flit_empty, rq_full, rq_empty;
    logic [$clog2(MAX_PACKETS+1)-1:0] rq_count;
    flit_novc_t       front;
    logic             in_is_head, wr_ok, rd_ok, front_is_tail, rq_pop;
    logic             wr_err, rd_err, vc_err;

    assign front         = flit_novc_t'(flit_rdata);
    assign in_is_head    = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);
    assign front_is_tail = (front.flit_label == TAIL) || (front.flit_label == HEADTAIL);

    // Full is checked on registered state, so a same-cycle read never makes
    // room for a write into a full buffer.
    assign wr_ok = write_i && !flit_full &&
                   ((in_is_head && !in_pkt_q && !rq_full) || (!in_is_head && in_pkt_q));
    assign rd_ok  = read_i && (state_q == StSa) && !flit_empty;
    assign rq_pop = rd_ok && front_is_tail;

    assign wr_err = write_i && !wr_ok;
    assign rd_err = read_i && !rd_ok;
    assign vc_err = vc_valid_i && (state_q != StVa);

    sync_fifo #(
        .WIDTH (FlitW),
        .DEPTH (BUFFER_SIZE)
    ) u_flit_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_ok),
        .wdata_i (data_i),
        .pop_i   (rd_ok),
        .rdata_o (flit_rdata),
        .full_o  (flit_full),
        .empty_o (flit_empty),
        .count_o (occupancy_o)
    );

    sync_fifo #(
        .WIDTH (PortW),
        .DEPTH (MAX_PACKETS)
    ) u_route_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_ok && in_is_head),
        .wdata_i (out_port_i),
        .pop_i   (rq_pop),
        .rdata_o (rq_rdata),
        .full_o  (rq_full),
        .empty_o (rq_empty),
        .count_o (rq_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            in_pkt_q        <= 1'b0;
            downstream_vc_q <= '0;
            credit_q        <= 1'b0;
            vc_alloc_q      <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            credit_q   <= rd_ok;
            vc_alloc_q <= 1'b0;
            error_q    <= wr_err || rd_err || vc_err;

            if (wr_ok) begin
                unique case (data_i.flit_label)
                    HEAD:          in_pkt_q <= 1'b1;
                    TAIL:          in_pkt_q <= 1'b0;
                    BODY, HEADTAIL: in_pkt_q <= in_pkt_q;
                    default:       in_pkt_q <= in_pkt_q;
                endcase
            end

            case (state_q)
                StIdle: if (!rq_empty) state_q <= StVa;
                StVa: begin
                    if (vc_valid_i) begin
                        downstream_vc_q <= vc_new_i;
                        state_q         <= StSa;
                    end
                end
                StSa: begin
                    if (rq_pop) begin
                        vc_alloc_q <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    vc_alloc_q <= 1'b1;
                    error_q    <= 1'b1;
                end
            endcase
        end
    end

    // Front flit is masked when empty so the output is clean after reset.
    always_comb begin
        data_o = '0;
        if (!flit_empty) begin
            data_o.flit_label = front.flit_label;
            data_o.vc_id      = downstream_vc_q;
            data_o.data       = front.data;
        end
    end

    assign is_full_o        = flit_full;
    assign is_empty_o       = flit_empty;
    assign credit_o         = credit_q;
    assign out_port_o       = rq_empty ? LOCAL : port_t'(rq_rdata);
    assign vc_request_o     = (state_q == StVa);
    assign switch_request_o = (state_q == StSa) && !flit_empty;
    assign vc_allocatable_o = vc_alloc_q;
    assign downstream_vc_o  = downstream_vc_q;
    assign error_o          = error_q;

    logic unused_rq_count;
    assign unused_rq_count = ^rq_count;

endmodule

// File: tb/tb_multi_packet_input_buffer.sv
// Directed self-checking bench for multi_packet_input_buffer
// (BUFFER_SIZE=8, MAX_PACKETS=2).
module tb_multi_packet_input_buffer;
    import noc_params::*;

    logic               clk = 1'b0;
    logic               rst;
    flit_novc_t         data_i;
    logic               write_i;
    port_t              out_port_i;
    logic               read_i;
    logic               vc_valid_i;
    logic [VC_SIZE-1:0] vc_new_i;
    flit_t              data_o;
    logic               is_full_o, is_empty_o;
    logic [3:0]         occupancy_o;
    logic               credit_o;
    port_t              out_port_o;
    logic               vc_request_o, switch_request_o, vc_allocatable_o;
    logic [VC_SIZE-1:0] downstream_vc_o;
    logic               error_o;

    int checks = 0;
    int errors = 0;
    flit_t exp_flit;

    always #5 clk = ~clk;

    multi_packet_input_buffer #(
        .BUFFER_SIZE (8),
        .MAX_PACKETS (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .data_i           (data_i),
        .write_i          (write_i),
        .out_port_i       (out_port_i),
        .read_i           (read_i),
        .vc_valid_i       (vc_valid_i),
        .vc_new_i         (vc_new_i),
        .data_o           (data_o),
        .is_full_o        (is_full_o),
        .is_empty_o       (is_empty_o),
        .occupancy_o      (occupancy_o),
        .credit_o         (credit_o),
        .out_port_o       (out_port_o),
        .vc_request_o     (vc_request_o),
        .switch_request_o (switch_request_o),
        .vc_allocatable_o (vc_allocatable_o),
        .downstream_vc_o  (downstream_vc_o),
        .error_o          (error_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input flit_label_t lbl, input logic [15:0] d, input port_t p);
        write_i           = 1'b1;
        data_i.flit_label = lbl;
        data_i.data       = d;
        out_port_i        = p;
    endtask

    task automatic idle_inputs();
        write_i    = 1'b0;
        read_i     = 1'b0;
        vc_valid_i = 1'b0;
        vc_new_i   = '0;
        data_i     = '0;
        out_port_i = LOCAL;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_occ", 32'(occupancy_o), 0);
        check("rst_empty", 32'(is_empty_o), 1);
        check("rst_port", 32'(out_port_o), 32'(LOCAL));
        check("rst_vcreq", 32'(vc_request_o), 0);
        check("rst_data", 32'(data_o), 0);
        rst = 1'b0;

        // Single HEADTAIL to EAST.
        drive_write(HEADTAIL, 16'h00A1, EAST);
        tick();
        idle_inputs();
        check("ht_occ", 32'(occupancy_o), 1);
        check("ht_port", 32'(out_port_o), 32'(EAST));
        check("ht_vcreq_t1", 32'(vc_request_o), 0);
        tick();
        check("ht_vcreq_t2", 32'(vc_request_o), 1);
        vc_valid_i = 1'b1;
        vc_new_i   = 2'd1;
        tick();
        idle_inputs();
        exp_flit.flit_label = HEADTAIL;
        exp_flit.vc_id      = 2'd1;
        exp_flit.data       = 16'h00A1;
        check("ht_data", 32'(data_o), 32'(exp_flit));
        check("ht_swreq", 32'(switch_request_o), 1);
        read_i = 1'b1;
        tick();
        idle_inputs();
        check("ht_credit", 32'(credit_o), 1);
        check("ht_vcalloc", 32'(vc_allocatable_o), 1);
        check("ht_empty", 32'(is_empty_o), 1);
        check("ht_err", 32'(error_o), 0);
        tick();
        check("ht_credit_off", 32'(credit_o), 0);

        // Packet A (NORTH) then packet B (SOUTH) back-to-back.
        drive_write(HEAD, 16'h0010, NORTH);
        tick();
        drive_write(BODY, 16'h0011, NORTH);
        tick();
        drive_write(TAIL, 16'h0012, NORTH);
        tick();
        drive_write(HEAD, 16'h0020, SOUTH);
        tick();
        drive_write(TAIL, 16'h0021, SOUTH);
        tick();
        idle_inputs();
        check("ab_occ", 32'(occupancy_o), 5);
        check("ab_port", 32'(out_port_o), 32'(NORTH));
        check("ab_err", 32'(error_o), 0);

        // Third head with two packets queued is dropped.
        drive_write(HEAD, 16'h0030, WEST);
        tick();
        idle_inputs();
        check("h3_err", 32'(error_o), 1);
        check("h3_occ", 32'(occupancy_o), 5);
        tick();
        check("h3_err_off", 32'(error_o), 0);
        check("ab_va", 32'(vc_request_o), 1);

        // read_i while in VA: error, no pop, still VA.
        read_i = 1'b1;
        tick();
        idle_inputs();
        check("rdva_err", 32'(error_o), 1);
        check("rdva_occ", 32'(occupancy_o), 5);
        check("rdva_state", 32'(vc_request_o), 1);

        vc_valid_i = 1'b1;
        vc_new_i   = 2'd2;
        tick();
        idle_inputs();
        check("a_dvc", 32'(downstream_vc_o), 2);
        check("a_swreq", 32'(switch_request_o), 1);

        // vc_valid_i while in SA: error, latched VC unchanged.
        vc_valid_i = 1'b1;
        vc_new_i   = 2'd3;
        tick();
        idle_inputs();
        check("vcsa_err", 32'(error_o), 1);
        check("vcsa_dvc", 32'(downstream_vc_o), 2);
        check("vcsa_swreq", 32'(switch_request_o), 1);

        read_i = 1'b1;
        tick();
        check("a_pop1_credit", 32'(credit_o), 1);
        check("a_pop1_occ", 32'(occupancy_o), 4);
        check("a_pop1_port", 32'(out_port_o), 32'(NORTH));
        check("a_pop1_vcalloc", 32'(vc_allocatable_o), 0);
        tick();
        tick();
        read_i = 1'b0;
        check("a_tail_vcalloc", 32'(vc_allocatable_o), 1);
        check("a_tail_port", 32'(out_port_o), 32'(SOUTH));
        check("a_tail_idle", 32'(vc_request_o), 0);
        check("a_tail_occ", 32'(occupancy_o), 2);
        check("a_tail_err", 32'(error_o), 0);
        tick();
        check("b_va_t2", 32'(vc_request_o), 1);

        vc_valid_i = 1'b1;
        vc_new_i   = 2'd3;
        tick();
        idle_inputs();
        exp_flit.flit_label = HEAD;
        exp_flit.vc_id      = 2'd3;
        exp_flit.data       = 16'h0020;
        check("b_data", 32'(data_o), 32'(exp_flit));
        read_i = 1'b1;
        tick();
        tick();
        idle_inputs();
        check("b_empty", 32'(is_empty_o), 1);
        check("b_vcalloc", 32'(vc_allocatable_o), 1);
        check("b_port", 32'(out_port_o), 32'(LOCAL));

        // BODY with no open packet.
        drive_write(BODY, 16'h0040, LOCAL);
        tick();
        idle_inputs();
        check("orphan_err", 32'(error_o), 1);
        check("orphan_occ", 32'(occupancy_o), 0);

        // Fill storage: HEAD plus seven BODY flits.
        drive_write(HEAD, 16'h0050, WEST);
        tick();
        for (int i = 1; i < 8; i++) begin
            drive_write(BODY, 16'(16'h0050 + i), WEST);
            tick();
        end
        idle_inputs();
        check("fill_full", 32'(is_full_o), 1);
        check("fill_occ", 32'(occupancy_o), 8);
        check("fill_va", 32'(vc_request_o), 1);
        vc_valid_i = 1'b1;
        vc_new_i   = 2'd1;
        tick();
        idle_inputs();
        // Write into full storage with a same-cycle read: write dropped.
        drive_write(BODY, 16'h005F, WEST);
        read_i = 1'b1;
        tick();
        idle_inputs();
        check("full_wr_err", 32'(error_o), 1);
        check("full_wr_occ", 32'(occupancy_o), 7);
        check("full_wr_credit", 32'(credit_o), 1);
        check("full_wr_notfull", 32'(is_full_o), 0);
        check("mid_swreq", 32'(switch_request_o), 1);

        // Asynchronous reset mid-packet.
        #2;
        rst = 1'b1;
        #1;
        check("arst_occ", 32'(occupancy_o), 0);
        check("arst_empty", 32'(is_empty_o), 1);
        check("arst_swreq", 32'(switch_request_o), 0);
        check("arst_dvc", 32'(downstream_vc_o), 0);
        check("arst_port", 32'(out_port_o), 32'(LOCAL));
        check("arst_credit", 32'(credit_o), 0);
        check("arst_data", 32'(data_o), 0);
        tick();
        rst = 1'b0;
        drive_write(HEAD, 16'h0060, EAST);
        tick();
        idle_inputs();
        check("post_rst_occ", 32'(occupancy_o), 1);
        check("post_rst_err", 32'(error_o), 0);
        check("post_rst_port", 32'(out_port_o), 32'(EAST));
        tick();
        check("post_rst_va", 32'(vc_request_o), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
